rom_dl_bridge: RTL and testbench

ROM_DL_BRIDGE -- requirements
Module: rom_dl_bridge

---
 rtl/rom_dl_pkg.sv | 32 +++
 rtl/dl_fifo.sv | 52 +++++
 rtl/rom_dl_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_rom_dl_bridge.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg: shared types for the ROM download bridge.
//   dl_state_t    - request FSM states (IDLE / WAIT)
//   fifo_entry_t  - one buffered SDRAM write {a, ds, d}
//   SDRAM_AW      - SDRAM word-address width
//   single_entry  - builds the entry for one lone byte
package rom_dl_pkg;

    localparam int SDRAM_AW = 23;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } dl_state_t;

    typedef struct packed {
        logic [SDRAM_AW-1:0] a;
        logic [1:0]          ds;
        logic [15:0]         d;
    } fifo_entry_t;

    // A lone byte goes to both halves of the word; the strobe selects the
    // half that matches the byte-address LSB (ds = {hi, lo}).
    function automatic fifo_entry_t single_entry(input logic [SDRAM_AW:0] addr,
                                                 input logic [7:0]        b);
        fifo_entry_t e;
        e.a  = addr[SDRAM_AW:1];
        e.ds = {addr[0], ~addr[0]};
        e.d  = {b, b};
        return e;
    endfunction

endpackage

// File: rtl/dl_fifo.sv
// dl_fifo: synchronous FIFO of fifo_entry_t with first-word-fall-through head.
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   push_i, din_i   - write request and entry; accepted when not full or popping
//   pop_i           - removes the head entry (ignored when empty)
//   head_o          - current head entry
//   full_o, empty_o - occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dl_fifo
    import rom_dl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  fifo_entry_t din_i,
    input  logic        pop_i,
    output fifo_entry_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, rd_q;
    fifo_entry_t mem_q [DEPTH];
    logic        do_push, do_pop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted when the head leaves at the same time.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/rom_dl_bridge.sv
// rom_dl_bridge: turns ioctl ROM-download byte strobes into toggle-handshake
// SDRAM word writes, buffered through dl_fifo.
//   clk_sys, reset_n                 - system clock, asynchronous active-low reset
//   ioctl_download/wr/addr/dout      - download side (byte strobes, rising edge counts)
//   port_req/ack                     - SDRAM toggle handshake
//   port_a/ds/d/we                   - SDRAM word address, byte strobes, data, write enable
//   busy, overflow, dl_done          - activity, sticky drop flag, completion pulse
// Optional build macro DL_WORD_MERGE_EN: pairs an even byte with the following
// odd byte into one 16-bit write.
module rom_dl_bridge
    import rom_dl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 25
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [ADDR_W-1:0]   ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic                port_req,
    input  logic                port_ack,
    output logic [SDRAM_AW-1:0] port_a,
    output logic [1:0]          port_ds,
    output logic [15:0]         port_d,
    output logic                port_we,
    output logic                busy,
    output logic                overflow,
    output logic                dl_done
);

    logic        wr_q, dl_q;
    logic        wr_rise, dl_rise, dl_fall;
    logic        push_vld_q, push_vld_d;
    fifo_entry_t push_ent_q, push_ent_d;
    logic        overflow_q, overflow_d;
    logic        done_pend_q, done_pend_d;
    dl_state_t   state_q, state_d;
    logic        req_q, req_d;
    fifo_entry_t out_q, out_d;
    logic        fifo_pop, fifo_full, fifo_empty;
    fifo_entry_t fifo_head;
    logic        hold_busy;
    logic        busy_int;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^ioctl_addr[ADDR_W-1:SDRAM_AW+1];

    assign wr_rise = ioctl_wr & ~wr_q & ioctl_download;
    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;

`ifdef DL_WORD_MERGE_EN
    logic              hold_vld_q, hold_vld_d;
    logic [ADDR_W-1:0] hold_a_q, hold_a_d;
    logic [7:0]        hold_b_q, hold_b_d;
    logic              pair_hit;

    assign hold_busy = hold_vld_q;
    assign pair_hit  = hold_vld_q & ~hold_a_q[0] & (ioctl_addr == hold_a_q + ADDR_W'(1));

    // Strobes are at least two cycles apart, so a byte parked here because of
    // a two-push collision (odd byte after an unrelated hold) drains in the
    // quiet cycle that follows.
    always_comb begin
        push_vld_d = 1'b0;
        push_ent_d = push_ent_q;
        hold_vld_d = hold_vld_q;
        hold_a_d   = hold_a_q;
        hold_b_d   = hold_b_q;
        if (wr_rise) begin
            if (pair_hit) begin
                push_vld_d    = 1'b1;
                push_ent_d.a  = ioctl_addr[SDRAM_AW:1];
                push_ent_d.ds = 2'b11;
                push_ent_d.d  = {ioctl_dout, hold_b_q};
                hold_vld_d    = 1'b0;
            end else begin
                if (hold_vld_q) begin
                    push_vld_d = 1'b1;
                    push_ent_d = single_entry(hold_a_q[SDRAM_AW:0], hold_b_q);
                end else if (ioctl_addr[0]) begin
                    push_vld_d = 1'b1;
                    push_ent_d = single_entry(ioctl_addr[SDRAM_AW:0], ioctl_dout);
                end
                if (hold_vld_q || !ioctl_addr[0]) begin
                    hold_vld_d = 1'b1;
                    hold_a_d   = ioctl_addr;
                    hold_b_d   = ioctl_dout;
                end
            end
        end else if (hold_vld_q && (hold_a_q[0] || dl_fall)) begin
            push_vld_d = 1'b1;
            push_ent_d = single_entry(hold_a_q[SDRAM_AW:0], hold_b_q);
            hold_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) hold_vld_q <= 1'b0;
        else          hold_vld_q <= hold_vld_d;
    end

    always_ff @(posedge clk_sys) begin
        hold_a_q <= hold_a_d;
        hold_b_q <= hold_b_d;
    end
`else
    assign hold_busy = 1'b0;

    always_comb begin
        push_vld_d = 1'b0;
        push_ent_d = push_ent_q;
        if (wr_rise) begin
            push_vld_d = 1'b1;
            push_ent_d = single_entry(ioctl_addr[SDRAM_AW:0], ioctl_dout);
        end
    end
`endif

    dl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_sys),
        .rst_ni  (reset_n),
        .push_i  (push_vld_q),
        .din_i   (push_ent_q),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The registered push stage counts as buffered content, so dl_done cannot
    // fire while the last byte is still on its way into the FIFO.
    assign busy_int = ioctl_download | push_vld_q | ~fifo_empty
                    | (state_q != ST_IDLE) | hold_busy;
    assign busy     = reset_n & busy_int;
    assign dl_done  = done_pend_q & ~busy_int;

    always_comb begin
        overflow_d = overflow_q;
        if (dl_rise) overflow_d = 1'b0;
        if (push_vld_q && fifo_full && !fifo_pop) overflow_d = 1'b1;

        done_pend_d = done_pend_q;
        if (dl_rise)      done_pend_d = 1'b0;
        else if (dl_fall) done_pend_d = 1'b1;
        else if (dl_done) done_pend_d = 1'b0;
    end

    // Request FSM: the head stays in the FIFO until acknowledged, and the
    // output registers are only reloaded in IDLE, which keeps a/ds/d stable.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        out_d    = out_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    out_d   = fifo_head;
                    req_d   = ~req_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (port_ack == req_q) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q        <= 1'b0;
            dl_q        <= 1'b0;
            push_vld_q  <= 1'b0;
            overflow_q  <= 1'b0;
            done_pend_q <= 1'b0;
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            out_q       <= '0;
        end else begin
            wr_q        <= ioctl_wr;
            dl_q        <= ioctl_download;
            push_vld_q  <= push_vld_d;
            overflow_q  <= overflow_d;
            done_pend_q <= done_pend_d;
            state_q     <= state_d;
            req_q       <= req_d;
            out_q       <= out_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        push_ent_q <= push_ent_d;
    end

    assign port_req = req_q;
    assign port_a   = out_q.a;
    assign port_ds  = out_q.ds;
    assign port_d   = out_q.d;
    assign port_we  = (state_q == ST_WAIT);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_rom_dl_bridge.sv
module tb_rom_dl_bridge;
    import rom_dl_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 25;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              ioctl_download = 1'b0;
    logic              ioctl_wr = 1'b0;
    logic [ADDR_W-1:0] ioctl_addr = '0;
    logic [7:0]        ioctl_dout = '0;
    logic              port_req;
    logic              port_ack = 1'b0;
    logic [22:0]       port_a;
    logic [1:0]        port_ds;
    logic [15:0]       port_d;
    logic              port_we;
    logic              busy;
    logic              overflow;
    logic              dl_done;

    rom_dl_bridge #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .port_req       (port_req),
        .port_ack       (port_ack),
        .port_a         (port_a),
        .port_ds        (port_ds),
        .port_d         (port_d),
        .port_we        (port_we),
        .busy           (busy),
        .overflow       (overflow),
        .dl_done        (dl_done)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    fifo_entry_t sb[$];

    function automatic fifo_entry_t exp_single(input logic [ADDR_W-1:0] a, input logic [7:0] b);
        fifo_entry_t e;
        e.a  = a[23:1];
        e.ds = {a[0], ~a[0]};
        e.d  = {b, b};
        return e;
    endfunction

    function automatic fifo_entry_t mk(input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
        fifo_entry_t e;
        e.a  = a;
        e.ds = ds;
        e.d  = d;
        return e;
    endfunction

    // SDRAM responder: checks each request against the scoreboard and
    // returns the acknowledge after ack_delay cycles unless held off.
    bit          ack_hold = 1'b0;
    bit          ack_now  = 1'b0;
    bit          pend     = 1'b0;
    logic        last_req = 1'b0;
    int          ack_delay = 2;
    int          ack_timer = 0;
    int          toggles   = 0;
    fifo_entry_t cur = '0;

    initial begin
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                port_ack = 1'b0;
                last_req = 1'b0;
                pend     = 1'b0;
            end else begin
                if (pend && (ack_now || (!ack_hold && ack_timer == 0))) begin
                    chk("stable_a", port_a, cur.a);
                    chk("stable_ds", port_ds, cur.ds);
                    chk("stable_d", port_d, cur.d);
                    port_ack = last_req;
                    pend     = 1'b0;
                    ack_now  = 1'b0;
                end else if (pend && !ack_hold) begin
                    ack_timer--;
                end
                if (port_req !== last_req) begin
                    last_req = port_req;
                    toggles++;
                    chk("req_while_pend", pend, 1'b0);
                    chk("sb_has_entry", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        cur = sb.pop_front();
                        chk("req_a", port_a, cur.a);
                        chk("req_ds", port_ds, cur.ds);
                        chk("req_d", port_d, cur.d);
                    end
                    chk("req_we", port_we, 1'b1);
                    pend      = 1'b1;
                    ack_timer = ack_delay;
                end
            end
        end
    end

    int done_cnt = 0;
    int exp_done = 0;
    initial begin
        forever begin
            @(negedge clk_sys);
            if (dl_done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1);
    end

    task automatic wr_byte(input logic [ADDR_W-1:0] a, input logic [7:0] b, input int hold);
        @(negedge clk_sys);
        ioctl_addr = a;
        ioctl_dout = b;
        ioctl_wr   = 1'b1;
        repeat (hold) @(negedge clk_sys);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic start_download(input string tag);
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        chk({tag, "_ovf_clear"}, overflow, 1'b0);
        chk({tag, "_busy_dl"}, busy, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sys);
            if (sb.size() == 0 && !pend && port_we === 1'b0) break;
        end
        chk({tag, "_drain_sb"}, sb.size(), 0);
        chk({tag, "_drain_we"}, port_we, 1'b0);
    endtask

    task automatic end_download(input string tag);
        bit seen;
        seen = 1'b0;
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            if (dl_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, seen, 1'b1);
        exp_done++;
        @(negedge clk_sys);
        chk({tag, "_done_once"}, dl_done, 1'b0);
    endtask

    task automatic wait_pend(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (pend) break;
            @(negedge clk_sys);
        end
        chk({tag, "_pend"}, pend, 1'b1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, port_req, 1'b0);
        chk({tag, "_we"}, port_we, 1'b0);
        chk({tag, "_a"}, port_a, 23'd0);
        chk({tag, "_ds"}, port_ds, 2'd0);
        chk({tag, "_d"}, port_d, 16'd0);
        chk({tag, "_ovf"}, overflow, 1'b0);
        chk({tag, "_done"}, dl_done, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    int t0;

    initial begin
        // reset state
        repeat (3) @(negedge clk_sys);
        chk_zero("rst");
        reset_n = 1'b1;
        @(negedge clk_sys);

        // single byte, latency, dl_done timing
        start_download("t1");
        ack_hold  = 1'b0;
        ack_delay = 5;
        t0 = toggles;
        @(negedge clk_sys);
        ioctl_addr = 25'h0003;
        ioctl_dout = 8'hA5;
        ioctl_wr   = 1'b1;
        sb.push_back(exp_single(25'h0003, 8'hA5));
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        chk("t1_lat_e1", port_req, 1'b0);
        @(negedge clk_sys);
        chk("t1_lat_e2", port_req, 1'b1);
        chk("t1_a", port_a, 23'h000001);
        chk("t1_ds", port_ds, 2'b10);
        chk("t1_d", port_d, 16'hA5A5);
        wait_drain("t1");
        chk("t1_toggles", toggles - t0, 1);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("t1_done_pulse", dl_done, 1'b1);
        chk("t1_busy_idle", busy, 1'b0);
        exp_done++;
        @(negedge clk_sys);
        chk("t1_done_once", dl_done, 1'b0);

        // overflow with acks withheld
        start_download("t2");
        ack_hold  = 1'b1;
        ack_delay = 2;
        t0 = toggles;
        for (int i = 0; i < 6; i++) begin
            if (i < FIFO_DEPTH)
                sb.push_back(exp_single(25'h101 + 25'(2 * i), 8'h10 + 8'(i)));
            wr_byte(25'h101 + 25'(2 * i), 8'h10 + 8'(i), 1);
        end
        repeat (2) @(negedge clk_sys);
        chk("t2_ovf", overflow, 1'b1);
        chk("t2_queued", sb.size(), FIFO_DEPTH - 1);
        chk("t2_outstanding", pend, 1'b1);
        ack_hold = 1'b0;
        wait_drain("t2");
        chk("t2_toggles", toggles - t0, FIFO_DEPTH);
        end_download("t2");

        // push and pop together while full
        start_download("t3");
        ack_hold = 1'b1;
        t0 = toggles;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            sb.push_back(exp_single(25'h301 + 25'(2 * i), 8'h40 + 8'(i)));
            wr_byte(25'h301 + 25'(2 * i), 8'h40 + 8'(i), 1);
        end
        @(negedge clk_sys);
        ioctl_addr = 25'h0311;
        ioctl_dout = 8'h4F;
        ioctl_wr   = 1'b1;
        sb.push_back(exp_single(25'h0311, 8'h4F));
        @(posedge clk_sys);
        #1 ack_now = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("t3_ovf", overflow, 1'b0);
        chk("t3_queued", sb.size(), FIFO_DEPTH - 1);
        ack_hold = 1'b0;
        wait_drain("t3");
        chk("t3_toggles", toggles - t0, FIFO_DEPTH + 1);
        end_download("t3");

        // long strobe
        start_download("t4");
        ack_delay = 1;
        t0 = toggles;
        sb.push_back(exp_single(25'h0201, 8'h3C));
        wr_byte(25'h0201, 8'h3C, 10);
        repeat (5) @(negedge clk_sys);
        wait_drain("t4");
        chk("t4_toggles", toggles - t0, 1);
        end_download("t4");

`ifdef DL_WORD_MERGE_EN
        // word merge and flush on download end
        start_download("t5");
        t0 = toggles;
        sb.push_back(mk(23'h08, 2'b11, 16'h2211));
        sb.push_back(mk(23'h09, 2'b01, 16'h3333));
        wr_byte(25'h10, 8'h11, 1);
        wr_byte(25'h11, 8'h22, 1);
        wr_byte(25'h12, 8'h33, 1);
        end_download("t5");
        chk("t5_toggles", toggles - t0, 2);
        chk("t5_sb", sb.size(), 0);
`endif

        // reset while waiting for ack
        start_download("t6");
        ack_hold = 1'b1;
        sb.push_back(exp_single(25'h0021, 8'h5A));
        wr_byte(25'h0021, 8'h5A, 1);
        wait_pend("t6");
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        #1;
        chk_zero("t6_rst");
        sb.delete();
        ack_hold = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        t0 = toggles;
        repeat (10) @(negedge clk_sys);
        chk("t6_no_toggle", toggles - t0, 0);
        chk("t6_req_low", port_req, 1'b0);
        start_download("t6b");
        sb.push_back(exp_single(25'h0041, 8'h77));
        wr_byte(25'h0041, 8'h77, 1);
        wait_drain("t6b");
        chk("t6b_toggles", toggles - t0, 1);
        end_download("t6b");

        repeat (3) @(negedge clk_sys);
        chk("done_total", done_cnt, exp_done);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
